// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared FSM state type and statistics width for the input-buffer controller.
package ibuf_pkg;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} ibuf_state_t;
  localparam int STAT_W = 16;
endpackage

// File: rtl/ibuf_ptr.sv
// ibuf_ptr: modulo-SIZE pointer with synchronous clear and variable advance.
module ibuf_ptr #(
  parameter int SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [$clog2(SIZE)-1:0] adv,
  output logic [$clog2(SIZE)-1:0] ptr
);
  // SIZE is a power of two, so natural wrap of the AW-bit sum is the modulo.
  always_ff @(posedge clk)
    ptr <= (rst || clr) ? '0 : ptr + adv;
endmodule

// File: rtl/ibuf_ctrl.sv
// ibuf_ctrl: fill/stream/drain controller for a circular input buffer.
// Define IBUF_CTRL_STATS_EN to add stat_words_in/stat_words_out word counters.
module ibuf_ctrl
  import ibuf_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int WRITE_SIZE = 2,
  parameter int READ_SIZE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      wr_valid,
  input  logic                      last_in,
  output logic                      wr_ready,
  input  logic                      rd_ready,
  input  logic [$clog2(READ_SIZE):0] rd_pop,
  output logic                      rd_valid,
  output logic                      buf_write_en,
  output logic [$clog2(SIZE)-1:0]   buf_write_addr,
  output logic [$clog2(SIZE)-1:0]   buf_read_addr,
  output logic [$clog2(SIZE):0]     count,
  output logic                      done
`ifdef IBUF_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_words_in,
  output logic [STAT_W-1:0]         stat_words_out
`endif
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = AW + 1;
  ibuf_state_t state;
  logic wr_fire, rd_fire, clr, active;
  logic [CW-1:0] pop, retired, count_next;
  always_comb begin
    active       = state == FILL || state == STREAM;
    wr_ready     = active && (CW'(SIZE) - count >= CW'(WRITE_SIZE));
    rd_valid     = state == DRAIN ? count != '0 : active && count >= CW'(READ_SIZE);
    wr_fire      = wr_valid && wr_ready;
    rd_fire      = rd_ready && rd_valid;
    buf_write_en = wr_fire;
    clr          = state == IDLE && start;
    pop          = CW'(rd_pop) < CW'(READ_SIZE) ? CW'(rd_pop) : CW'(READ_SIZE);
    retired      = !rd_fire ? '0 : pop < count ? pop : count;
    count_next   = count + (wr_fire ? CW'(WRITE_SIZE) : '0) - retired;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done  <= state == DRAIN && count_next == '0;
      count <= clr ? '0 : count_next;
      state <= state == IDLE ? (start ? FILL : IDLE) :
               (state != DRAIN && wr_fire && last_in) ? DRAIN :
               (state == FILL && count_next >= CW'(READ_SIZE)) ? STREAM :
               (state == DRAIN && count_next == '0) ? IDLE : state;
    end
  end
  ibuf_ptr #(.SIZE(SIZE)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(clr),
    .adv(wr_fire ? AW'(WRITE_SIZE) : '0),
    .ptr(buf_write_addr)
  );
  ibuf_ptr #(.SIZE(SIZE)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(clr),
    .adv(retired[AW-1:0]),
    .ptr(buf_read_addr)
  );
`ifdef IBUF_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_in  <= '0;
      stat_words_out <= '0;
    end else begin
      if (wr_fire) stat_words_in <= stat_words_in + STAT_W'(WRITE_SIZE);
      if (rd_fire) stat_words_out <= stat_words_out + STAT_W'(retired);
    end
  end
`endif
endmodule
